// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial frame receiver.
// The line is double-flopped into rx_s. A falling rx_s seen in IDLE is the
// reference edge E0. Every bit is then sampled at its centre by a clock-count
// timer: H cycles after E0 for the start bit, then one bit period later for
// each data bit and for the stop bit. Good frames load data and pulse
// data_valid. A zero stop bit pulses frame_err, and the receiver then waits in
// BREAK for the line to return high.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int TW = $clog2(CLKS_PER_BIT);

   // Timer values seen on the sampling edges. The timer reads 0 on the edge
   // that enters a state, so a count of N cycles ends when it reads N-1.
   localparam logic [TW-1:0] MID_LAST = TW'(H - 1);
   localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

   if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT > 65535)) begin : g_bad_cpb
      $error("uart_rx: CLKS_PER_BIT must lie in 4..65535");
   end

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BRK   = 3'd4
   } state_t;

   state_t          state_r, state_s;
   logic            rx_meta_r;
   logic            rx_s;
   logic [TW-1:0]   timer_r, timer_s;
   logic [2:0]      idx_r, idx_s;
   logic [7:0]      shift_r, shift_s;
   logic [7:0]      data_s;
   logic            valid_s;
   logic            ferr_s;

   // Next-state, bit timer, bit index, shift register and strobe decode.
   always_comb begin
      state_s = state_r;
      timer_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
      idx_s   = idx_r;
      shift_s = shift_r;
      data_s  = data;
      valid_s = 1'b0;
      ferr_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            timer_s = {TW{1'b0}};
            idx_s   = 3'd0;
            if (rx_s == 1'b0) begin
               state_s = ST_START;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (timer_r == MID_LAST) begin
               timer_s = {TW{1'b0}};
               if (rx_s == 1'b0) begin
                  state_s = ST_DATA;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (timer_r == BIT_LAST) begin
               timer_s = {TW{1'b0}};
               shift_s = {rx_s, shift_r[7:1]};
               if (idx_r == 3'd7) begin
                  idx_s   = 3'd0;
                  state_s = ST_STOP;
               end else begin
                  idx_s   = idx_r + 3'd1;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_STOP: begin
            if (timer_r == BIT_LAST) begin
               timer_s = {TW{1'b0}};
               if (rx_s == 1'b1) begin
                  data_s  = shift_r;
                  valid_s = 1'b1;
                  state_s = ST_IDLE;
               end else begin
                  ferr_s  = 1'b1;
                  state_s = ST_BRK;
               end
            end else begin
               state_s = ST_STOP;
            end
         end
         ST_BRK: begin
            // A line held low must go high again before a new start is armed.
            timer_s = {TW{1'b0}};
            if (rx_s == 1'b1) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_BRK;
            end
         end
         default: begin
            state_s = ST_IDLE;
            timer_s = {TW{1'b0}};
            idx_s   = 3'd0;
         end
      endcase
   end

   // Synchroniser, FSM state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_r  <= 1'b1;
         rx_s       <= 1'b1;
         state_r    <= ST_IDLE;
         timer_r    <= {TW{1'b0}};
         idx_r      <= 3'd0;
         shift_r    <= 8'h00;
         data       <= 8'h00;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rx_meta_r  <= rx;
         rx_s       <= rx_meta_r;
         state_r    <= state_s;
         timer_r    <= timer_s;
         idx_r      <= idx_s;
         shift_r    <= shift_s;
         data       <= data_s;
         data_valid <= valid_s;
         frame_err  <= ferr_s;
         busy       <= (state_s != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx. It drives directed frames and keeps a timeline model
// of when each strobe must appear, what data must hold and when busy must be
// high, all derived from the frame start time.
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int H    = CPB / 2;
   localparam int BIG  = 32'h7fffffff;
   // Line change to E0: two synchroniser flops plus the detecting edge.
   localparam int LAT  = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       data_valid, frame_err, busy;

   logic       rx4 = 1'b1;
   logic [7:0] data4;
   logic       data_valid4, frame_err4, busy4;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .rx(rx), .data(data),
      .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
   );

   uart_rx #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rst(rst), .rx(rx4), .data(data4),
      .data_valid(data_valid4), .frame_err(frame_err4), .busy(busy4)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      bit         is_valid;
      logic [7:0] val;
   } ev_t;

   typedef struct {
      int s;
      int e;
   } iv_t;

   ev_t        evq[$];
   iv_t        bq[$];
   logic [7:0] exp_data = 8'h00;

   int         cyc = 0;
   int         n_checks = 0;
   int         n_err = 0;
   logic [7:0] vq[$];
   int         vcyc[$];
   int         ferr_cnt = 0;
   int         v4_cnt = 0;
   int         f4_cnt = 0;
   int         v4_cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Cycle counter for the timeline model.
   always @(posedge clk) cyc = cyc + 1;

   // Per-cycle comparison of every output against the timeline model.
   always @(negedge clk) begin
      logic exp_v, exp_f, exp_b;
      exp_v = 1'b0;
      exp_f = 1'b0;
      exp_b = 1'b0;
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
         if (evq[0].is_valid) begin
            exp_v    = 1'b1;
            exp_data = evq[0].val;
         end else begin
            exp_f = 1'b1;
         end
         void'(evq.pop_front());
      end
      foreach (bq[i]) begin
         if (cyc >= bq[i].s && cyc < bq[i].e) exp_b = 1'b1;
      end
      chk("data", {24'h0, data}, {24'h0, exp_data});
      chk("data_valid", {31'h0, data_valid}, {31'h0, exp_v});
      chk("frame_err", {31'h0, frame_err}, {31'h0, exp_f});
      chk("busy", {31'h0, busy}, {31'h0, exp_b});
      if (data_valid) begin
         vq.push_back(data);
         vcyc.push_back(cyc);
      end
      if (frame_err) ferr_cnt++;
      if (data_valid4) begin
         v4_cnt++;
         v4_cyc = cyc;
      end
      if (frame_err4) f4_cnt++;
   end

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One frame; the model learns when the stop sample lands and what it yields.
   task automatic send(input logic [7:0] b, input logic stopv, input int stop_len);
      int c;
      int ev_cyc;
      c      = cyc;
      ev_cyc = c + LAT + H + 9 * CPB;
      evq.push_back('{ev_cyc, stopv, b});
      bq.push_back('{c + LAT, (stopv ? ev_cyc : BIG)});
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(b[i], CPB);
      hold(stopv, stop_len);
   endtask

   initial begin
      int         c;
      int         r;
      logic [7:0] b81;
      logic [9:0] f4;

      rx  = 1'b1;
      rx4 = 1'b1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data", {24'h0, data}, 32'h0);
      chk("reset_busy", {31'h0, busy}, 32'h0);
      rst = 1'b0;
      hold(1'b1, 5);

      // Clean 0xA5 frame.
      send(8'hA5, 1'b1, CPB);
      hold(1'b1, 20);
      chk("a5_count", vq.size(), 32'd1);
      chk("a5_value", {24'h0, vq[0]}, 32'h0000_00A5);

      // Four-cycle low glitch: busy for H cycles from E0, then back to idle.
      c = cyc;
      bq.push_back('{c + LAT, c + LAT + H});
      hold(1'b0, 4);
      hold(1'b1, 30);
      chk("glitch_count", vq.size(), 32'd1);
      chk("glitch_data", {24'h0, data}, 32'h0000_00A5);
      chk("glitch_ferr", ferr_cnt, 32'd0);

      // 0x3C with a zero stop bit and a held-low line afterwards.
      send(8'h3C, 1'b0, 40);
      r = cyc;
      bq[bq.size() - 1].e = r + LAT;
      hold(1'b1, 40);
      chk("brk_ferr", ferr_cnt, 32'd1);
      chk("brk_count", vq.size(), 32'd1);
      chk("brk_data", {24'h0, data}, 32'h0000_00A5);

      // Back-to-back 0x00 then 0xFF with no idle gap.
      send(8'h00, 1'b1, CPB);
      send(8'hFF, 1'b1, CPB);
      hold(1'b1, 20);
      chk("b2b_count", vq.size(), 32'd3);
      chk("b2b_first", {24'h0, vq[1]}, 32'h0000_0000);
      chk("b2b_second", {24'h0, vq[2]}, 32'h0000_00FF);
      chk("b2b_gap", vcyc[2] - vcyc[1], 32'd160);

      // Reset in the middle of data bit 4 of 0x81.
      b81 = 8'h81;
      c = cyc;
      bq.push_back('{c + LAT, BIG});
      hold(1'b0, CPB);
      for (int i = 0; i < 4; i++) hold(b81[i], CPB);
      hold(b81[4], 5);
      rst = 1'b1;
      rx  = 1'b1;
      evq.delete();
      bq.delete();
      exp_data = 8'h00;
      #1;
      chk("midrst_data", {24'h0, data}, 32'h0);
      chk("midrst_busy", {31'h0, busy}, 32'h0);
      chk("midrst_valid", {31'h0, data_valid}, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      hold(1'b1, 5);
      send(8'h42, 1'b1, CPB);
      hold(1'b1, 20);
      chk("after_rst_count", vq.size(), 32'd4);
      chk("after_rst_value", {24'h0, vq[3]}, 32'h0000_0042);

      // Four-clock-per-bit instance fed by a bench-side transmitter.
      f4 = {1'b1, 8'h5A, 1'b0};
      c = cyc;
      for (int i = 0; i < 10; i++) begin
         rx4 = f4[i];
         repeat (4) @(posedge clk);
         #1;
      end
      rx4 = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("cpb4_count", v4_cnt, 32'd1);
      chk("cpb4_data", {24'h0, data4}, 32'h0000_005A);
      chk("cpb4_ferr", f4_cnt, 32'd0);
      chk("cpb4_time", v4_cyc - c, 32'd41);

      chk("events_drained", evq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
